// File: rtl/controller_responder.sv
`default_nettype none
// ============================================================================
// Module      : controller_responder
// Description : Controller-side endpoint of the serial gamepad link. Captures
//               an 8-bit button word on the console latch and shifts it out
//               active-low on data_B, one bit per console clock rise.
//               Optional macro CONTROLLER_RESPONDER_DPAD_FILTER_EN clears
//               opposing d-pad pairs (up+down, left+right) on the load path.
// Revision    : 1.0 - initial release
// ============================================================================
module controller_responder #(
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_BIT    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] buttons_in,
    input  logic       controller_clk,
    input  logic       controller_latch,
    output logic       data_B,
    output logic [3:0] bits_sent,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] C_FRAME_BITS = 4'd8;

    logic [SYNC_STAGES-1:0] cclk_sync_q;
    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic                   cclk_hist_q;
    logic                   latch_hist_q;

    logic cclk_sync;
    logic latch_sync;
    logic cclk_rise;
    logic latch_fall;

    state_e     state_q, state_d;
    // Bit 0 of the logical shift register lives inverted in data_q, so only
    // bits 7..1 are held here.
    logic [7:1] shift_q, shift_d;
    logic       data_q, data_d;
    logic [3:0] bits_q, bits_d;
    logic       done_q, done_d;

    logic [7:0] load_word;

`ifdef CONTROLLER_RESPONDER_DPAD_FILTER_EN
    always_comb begin
        load_word = buttons_in;
        if (buttons_in[4] && buttons_in[5]) begin
            load_word[5:4] = 2'b00;
        end
        if (buttons_in[6] && buttons_in[7]) begin
            load_word[7:6] = 2'b00;
        end
    end
`else
    assign load_word = buttons_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cclk_sync_q  <= '0;
            latch_sync_q <= '0;
            cclk_hist_q  <= 1'b0;
            latch_hist_q <= 1'b0;
        end else begin
            cclk_sync_q  <= {cclk_sync_q[SYNC_STAGES-2:0], controller_clk};
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], controller_latch};
            cclk_hist_q  <= cclk_sync_q[SYNC_STAGES-1];
            latch_hist_q <= latch_sync_q[SYNC_STAGES-1];
        end
    end

    assign cclk_sync  = cclk_sync_q[SYNC_STAGES-1];
    assign latch_sync = latch_sync_q[SYNC_STAGES-1];
    assign cclk_rise  = cclk_sync & ~cclk_hist_q;
    assign latch_fall = latch_hist_q & ~latch_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            data_q  <= 1'b1;
            bits_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            bits_q  <= bits_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        bits_d  = bits_q;
        done_d  = 1'b0;

        if (latch_sync) begin
            // Transparent load every cycle the latch is high; clock rises lose.
            state_d = S_LOAD;
            shift_d = load_word[7:1];
            data_d  = ~load_word[0];
            bits_d  = 4'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cclk_rise) begin
                        shift_d = {FILL_BIT, shift_q[7:2]};
                        data_d  = ~shift_q[1];
                    end
                end
                S_LOAD, S_SHIFT: begin
                    if (state_q == S_LOAD && latch_fall) begin
                        state_d = S_SHIFT;
                    end
                    if (cclk_rise) begin
                        shift_d = {FILL_BIT, shift_q[7:2]};
                        data_d  = ~shift_q[1];
                        bits_d  = bits_q + 4'd1;
                        if (bits_q == C_FRAME_BITS - 4'd1) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign data_B     = data_q;
    assign bits_sent  = bits_q;
    assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_controller_responder.sv
`default_nettype none
// Directed, table-driven bench for controller_responder: latch/shift frames
// with hand-computed data_B sequences, plus multi-cycle corner sequences.
module tb_controller_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] buttons_in;
    logic       controller_clk;
    logic       controller_latch;
    logic       data_B;
    logic [3:0] bits_sent;
    logic       frame_done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fd_cnt    = 0;

    controller_responder #(
        .SYNC_STAGES(2),
        .FILL_BIT   (1'b0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .buttons_in      (buttons_in),
        .controller_clk  (controller_clk),
        .controller_latch(controller_latch),
        .data_B          (data_B),
        .bits_sent       (bits_sent),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    typedef struct {
        logic [7:0]  buttons;
        int          pulses;
        logic [10:0] exp_data;   // bit 0: after load, bit k: after k-th clock pulse
        logic [3:0]  exp_bits;
        int          exp_frames;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic latch_pulse();
        controller_latch = 1'b1;
        cycles(6);
        controller_latch = 1'b0;
        cycles(6);
    endtask

    task automatic cclk_pulse();
        controller_clk = 1'b1;
        cycles(6);
        controller_clk = 1'b0;
        cycles(6);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] expd;
        int          fd0;

        vecs[0] = '{8'hFE, 8,  11'h101, 4'd8, 1};
        vecs[1] = '{8'hFF, 10, 11'h700, 4'd8, 1};
        vecs[2] = '{8'hFF, 3,  11'h000, 4'd3, 0};
        vecs[3] = '{8'hA5, 8,  11'h15A, 4'd8, 1};
`ifdef CONTROLLER_RESPONDER_DPAD_FILTER_EN
        vecs[4] = '{8'hF0, 8,  11'h1FF, 4'd8, 1};
`else
        vecs[4] = '{8'hF0, 8,  11'h10F, 4'd8, 1};
`endif
        vecs[5] = '{8'h00, 3,  11'h00F, 4'd3, 0};

        rst              = 1'b1;
        buttons_in       = 8'h3C;
        controller_clk   = 1'b0;
        controller_latch = 1'b0;
        cycles(3);
        check("reset_data_B", {7'd0, data_B}, 8'd1);
        check("reset_bits_sent", {4'd0, bits_sent}, 8'd0);
        check("reset_frame_done", {7'd0, frame_done}, 8'd0);
        rst = 1'b0;
        cycles(2);

        for (int v = 0; v < 6; v++) begin
            expd       = vecs[v].exp_data;
            buttons_in = vecs[v].buttons;
            fd0        = fd_cnt;
            latch_pulse();
            // Changing the live buttons after the latch must not affect the frame.
            buttons_in = ~vecs[v].buttons;
            check($sformatf("v%0d load_data_B", v), {7'd0, data_B}, {7'd0, expd[0]});
            check($sformatf("v%0d load_bits_sent", v), {4'd0, bits_sent}, 8'd0);
            for (int k = 1; k <= vecs[v].pulses; k++) begin
                cclk_pulse();
                check($sformatf("v%0d pulse%0d data_B", v, k), {7'd0, data_B}, {7'd0, expd[k]});
                check($sformatf("v%0d pulse%0d bits_sent", v, k), {4'd0, bits_sent},
                      (k > 8) ? 8'd8 : 8'(k));
            end
            check($sformatf("v%0d final_bits_sent", v), {4'd0, bits_sent}, {4'd0, vecs[v].exp_bits});
            check($sformatf("v%0d frame_done_count", v), 8'(fd_cnt - fd0), 8'(vecs[v].exp_frames));
        end

        // Latch and clock rise together: the load wins and nothing shifts.
        buttons_in       = 8'h01;
        fd0              = fd_cnt;
        controller_latch = 1'b1;
        controller_clk   = 1'b1;
        cycles(6);
        check("simul data_B", {7'd0, data_B}, 8'd0);
        check("simul bits_sent", {4'd0, bits_sent}, 8'd0);
        controller_latch = 1'b0;
        cycles(6);
        check("simul after_latch bits_sent", {4'd0, bits_sent}, 8'd0);
        controller_clk = 1'b0;
        cycles(6);
        check("simul after_clk data_B", {7'd0, data_B}, 8'd0);
        check("simul after_clk bits_sent", {4'd0, bits_sent}, 8'd0);
        cclk_pulse();
        check("simul next data_B", {7'd0, data_B}, 8'd1);
        check("simul next bits_sent", {4'd0, bits_sent}, 8'd1);
        check("simul frame_done_count", 8'(fd_cnt - fd0), 8'd0);

        // Reset with the latch held high: outputs clear, then a fresh load appears.
        buttons_in       = 8'h01;
        controller_latch = 1'b1;
        cycles(6);
        check("rstmid loaded data_B", {7'd0, data_B}, 8'd0);
        rst = 1'b1;
        cycles(1);
        check("rstmid data_B", {7'd0, data_B}, 8'd1);
        check("rstmid bits_sent", {4'd0, bits_sent}, 8'd0);
        rst = 1'b0;
        cycles(1);
        check("rstmid early data_B", {7'd0, data_B}, 8'd1);
        cycles(4);
        check("rstmid reload data_B", {7'd0, data_B}, 8'd0);
        check("rstmid reload bits_sent", {4'd0, bits_sent}, 8'd0);
        controller_latch = 1'b0;
        cycles(6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
